// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage register hazard control with per-register pending-write counters
//
// Tracks outstanding GPR writes between issue (ID->EX handoff) and writeback,
// and holds the ID stage while the instruction there would read a register
// with a write in flight (RAW) or would push a destination's pending-write
// count past its 2-bit capacity (WAW).
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous active-high reset, clears all tracking state
//   id_valid      ID stage holds a valid instruction
//   id_raddr1     first source register (rj)
//   id_raddr2     second source register (rk or rd)
//   id_use1       instruction reads id_raddr1
//   id_use2       instruction reads id_raddr2
//   id_gr_we      instruction writes a GPR
//   id_dest       GPR destination of the ID instruction
//   ex_allow_in   EX stage accepts an instruction this cycle
//   wb_we         WB writes the register file this cycle
//   wb_dest       WB destination register
//   id_ready_go   ID may hand off to EX (combinational, no hazard present)
//   busy_vec      bit n set while register n has at least one pending write
//   stall_cycles  saturating count of cycles ID was held by this block

module id_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_raddr1,
    input  logic [4:0]  id_raddr2,
    input  logic        id_use1,
    input  logic        id_use2,
    input  logic        id_gr_we,
    input  logic [4:0]  id_dest,
    input  logic        ex_allow_in,
    input  logic        wb_we,
    input  logic [4:0]  wb_dest,
    output logic        id_ready_go,
    output logic [31:0] busy_vec,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0]  CNT_MAX   = 2'd3;
    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    // Pending-write counters; register 0 is hardwired and has no counter.
    logic [1:0]  cnt [1:31];

    // Per-register views of the counters, indexed 0..31 with bit 0 forced low
    // so that lookups by any 5-bit address never need a special case for r0.
    logic [31:0] full_vec;

    logic        raw;
    logic        waw;
    logic        hazard;
    logic        issue;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;

    always_comb begin
        busy_vec    = '0;
        full_vec    = '0;
        for (int n = 1; n < 32; n++) begin
            busy_vec[n] = (cnt[n] != 2'd0);
            full_vec[n] = (cnt[n] == CNT_MAX);
        end
    end

    // Hazard detection looks only at registered counter state, so a writeback
    // in the current cycle does not release a dependent instruction until the
    // following cycle; the register file has no write-through path.
    always_comb begin
        raw         = (id_use1 & busy_vec[id_raddr1]) | (id_use2 & busy_vec[id_raddr2]);
        waw         = id_gr_we & full_vec[id_dest];
        hazard      = id_valid & (raw | waw);
        id_ready_go = ~hazard;
        issue       = id_valid & id_ready_go & ex_allow_in;
    end

    // One-hot increment/decrement requests. Bit 0 is masked out of the
    // increment; the decrement is masked by busy_vec, which both drops r0 and
    // ignores a writeback to a register with nothing pending.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue && id_gr_we) begin
            inc_vec = (32'd1 << id_dest) & ~32'd1;
        end
        if (wb_we) begin
            dec_vec = (32'd1 << wb_dest) & busy_vec;
        end
    end

    // An increment and decrement hitting the same register cancel out.
    // Overflow cannot occur: waw keeps a full register from issuing again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 1; n < 32; n++) begin
                cnt[n] <= 2'd0;
            end
        end else begin
            for (int n = 1; n < 32; n++) begin
                if (inc_vec[n] && !dec_vec[n]) begin
                    cnt[n] <= cnt[n] + 2'd1;
                end else if (dec_vec[n] && !inc_vec[n]) begin
                    cnt[n] <= cnt[n] - 2'd1;
                end
            end
        end
    end

    // Only hazard stalls are counted; back-pressure from EX (ex_allow_in = 0)
    // with no hazard leaves the counter alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (hazard && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed and randomized checks of id_hazard_ctrl against a counter-array model

module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_raddr1;
    logic [4:0]  id_raddr2;
    logic        id_use1;
    logic        id_use2;
    logic        id_gr_we;
    logic [4:0]  id_dest;
    logic        ex_allow_in;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic        id_ready_go;
    logic [31:0] busy_vec;
    logic [31:0] stall_cycles;

    int          total = 0;
    int          bad   = 0;

    // Reference model: plain integer pending-write count per register.
    int          m_cnt [32];
    logic [31:0] m_stall;

    id_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_raddr1    (id_raddr1),
        .id_raddr2    (id_raddr2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .id_gr_we     (id_gr_we),
        .id_dest      (id_dest),
        .ex_allow_in  (ex_allow_in),
        .wb_we        (wb_we),
        .wb_dest      (wb_dest),
        .id_ready_go  (id_ready_go),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy(input int r);
        return (r != 0) && (m_cnt[r] > 0);
    endfunction

    function automatic bit m_ready();
        bit rd_haz;
        bit wr_haz;
        rd_haz = (id_use1 && m_busy(id_raddr1)) || (id_use2 && m_busy(id_raddr2));
        wr_haz = id_gr_we && (id_dest != 0) && (m_cnt[id_dest] == 3);
        return !(id_valid && (rd_haz || wr_haz));
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 1; r < 32; r++) v[r] = (m_cnt[r] > 0);
        return v;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_stall = '0;
    endtask

    // Apply this cycle's effects to the model using inputs as seen before the edge.
    task automatic m_step();
        bit rdy;
        bit inc;
        bit dec;
        rdy = m_ready();
        inc = id_valid && rdy && ex_allow_in && id_gr_we && (id_dest != 0);
        dec = wb_we && (wb_dest != 0) && (m_cnt[wb_dest] > 0);
        if (id_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (inc && dec && id_dest == wb_dest) begin
            // cancel
        end else begin
            if (inc) m_cnt[id_dest] = m_cnt[id_dest] + 1;
            if (dec) m_cnt[wb_dest] = m_cnt[wb_dest] - 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic drive(input bit v, input int ra1, input bit u1, input int ra2, input bit u2,
                         input bit we, input int dst, input bit allow, input bit wbw, input int wbd);
        id_valid    = v;
        id_raddr1   = 5'(ra1);
        id_use1     = u1;
        id_raddr2   = 5'(ra2);
        id_use2     = u2;
        id_gr_we    = we;
        id_dest     = 5'(dst);
        ex_allow_in = allow;
        wb_we       = wbw;
        wb_dest     = 5'(wbd);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"}, {31'b0, id_ready_go}, {31'b0, m_ready()});
        chk({tag, ".busy"},  busy_vec, m_busy_vec());
        chk({tag, ".stall"}, stall_cycles, m_stall);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        m_clear();
        chk("rst.busy",  busy_vec, 32'h0);
        chk("rst.stall", stall_cycles, 32'h0);
        chk("rst.ready", {31'b0, id_ready_go}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int wb_pick;
        int nb;
        reset = 1'b1;
        idle();
        m_clear();
        #2;
        chk("init.busy",  busy_vec, 32'h0);
        chk("init.stall", stall_cycles, 32'h0);
        chk("init.ready", {31'b0, id_ready_go}, 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // r0 is never tracked
        drive(1, 0, 1, 0, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("r0.ready", {31'b0, id_ready_go}, 32'h1);
            cycle();
            chk("r0.busy", busy_vec, 32'h0);
        end

        // issue r5, dependent read stalls
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        chk("raw.issue_ready", {31'b0, id_ready_go}, 32'h1);
        cycle();
        chk("raw.busy", busy_vec, 32'h20);
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
        chk("raw.stall_ready", {31'b0, id_ready_go}, 32'h0);
        cycle();
        cycle();
        chk("raw.stall2", stall_cycles, 32'd2);

        // writeback r5: still stalled this cycle, released next
        drive(1, 5, 1, 0, 0, 0, 0, 1, 1, 5);
        chk("wb.same_cycle_ready", {31'b0, id_ready_go}, 32'h0);
        cycle();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
        chk("wb.next_ready", {31'b0, id_ready_go}, 32'h1);
        chk("wb.busy", busy_vec, 32'h0);
        chk("wb.stall3", stall_cycles, 32'd3);
        cycle();

        // three writes to r7 fill the counter; a fourth is a WAW hazard
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        cycle();
        cycle();
        cycle();
        chk("waw.busy", busy_vec, 32'h80);
        chk("waw.ready", {31'b0, id_ready_go}, 32'h0);
        drive(1, 0, 0, 0, 0, 1, 7, 1, 1, 7);
        cycle();
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        chk("waw.release", {31'b0, id_ready_go}, 32'h1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        cycle();
        cycle();
        chk("waw.drain2_busy", busy_vec, 32'h80);
        cycle();
        chk("waw.drain_busy", busy_vec, 32'h0);

        // same-cycle issue and WB on r9 cancel
        drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 1, 9, 1, 1, 9);
        chk("cancel.ready", {31'b0, id_ready_go}, 32'h1);
        cycle();
        chk("cancel.busy", busy_vec, 32'h200);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
        cycle();
        chk("cancel.cnt_was_1", busy_vec, 32'h0);

        // EX back-pressure alone is not counted as a stall
        drive(1, 3, 1, 4, 1, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        check_model("backpressure");

        // async reset mid-cycle with r4..r11 pending and 12 stall cycles
        idle();
        do_reset();
        for (int r = 4; r < 12; r++) begin
            drive(1, 0, 0, 0, 0, 1, r, 1, 0, 0);
            cycle();
        end
        drive(1, 4, 1, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cycle();
        chk("pre_rst.busy",  busy_vec, 32'h0000_0FF0);
        chk("pre_rst.stall", stall_cycles, 32'd12);
        do_reset();
        check_model("post_rst");

        // randomized traffic on a small register window
        for (int i = 0; i < 400; i++) begin
            wb_pick = 0;
            nb = 0;
            for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) nb++;
            if (nb > 0 && $urandom_range(0, 2) != 0) begin
                int k;
                k = $urandom_range(1, nb);
                for (int r = 1; r < 8; r++) begin
                    if (m_cnt[r] > 0) begin
                        k--;
                        if (k == 0) wb_pick = r;
                    end
                end
            end
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 4) != 0,
                  wb_pick != 0, wb_pick);
            check_model("rand");
            cycle();
            if ($urandom_range(0, 149) == 0) do_reset();
        end
        idle();
        check_model("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have: id_valid  in  1  ID stage holds a valid instruction.
REQ-004 SHALL have: id_raddr1  in  5  first source register (rj).
REQ-005 SHALL have: id_raddr2  in  5  second source register (rk or rd).
REQ-006 SHALL have: id_use1 / id_use2  in  1 each  instruction actually reads raddr1 / raddr2.
REQ-007 SHALL have: id_gr_we  in  1  instruction writes a GPR; id_dest  in  5  its destination.
REQ-008 SHALL have: ex_allow_in  in  1  EX stage accepts this cycle.
REQ-009 SHALL have: wb_we  in  1  WB writes regfile this cycle; wb_dest  in  5  WB destination.
REQ-010 SHALL have: id_ready_go  out  1  ID may hand off to EX.
REQ-011 SHALL have: busy_vec  out  32  bit n set when register n has a pending write.
REQ-012 SHALL have: stall_cycles  out  32  count of cycles ID stalled by this block.

Function
REQ-013 SHALL keep one 2-bit pending-write counter cnt[n] per register n = 1..31; register 0 has no counter and is never busy.
REQ-014 SHALL define issue = id_valid & id_ready_go & ex_allow_in.
REQ-015 SHALL define raw = id_use1 & busy(id_raddr1) | id_use2 & busy(id_raddr2), where busy(n) = (cnt[n] != 0) and busy(0) = 0.
REQ-016 SHALL define waw = id_gr_we & (id_dest != 0) & (cnt[id_dest] == 3).
REQ-017 SHALL drive id_ready_go = ~(raw | waw) combinationally; with id_valid = 0 it is 1.
REQ-018 SHALL, on issue with id_gr_we = 1 and id_dest != 0, increment cnt[id_dest] at the next edge.
REQ-019 SHALL, on wb_we = 1 with wb_dest != 0, decrement cnt[wb_dest] at the next edge.
REQ-020 SHALL leave cnt unchanged when increment and decrement target the same register in the same cycle.
REQ-021 SHALL apply independent increment and decrement to different registers in the same cycle.
REQ-022 SHALL not let a decrement wrap below 0; a WB to a register with cnt = 0 is ignored. This is a protocol error and is a verification assertion.
REQ-023 SHALL not let an increment exceed 3; this is guaranteed by waw blocking.
REQ-024 SHALL make the same-cycle WB decrement invisible to id_ready_go; the dependent instruction issues one cycle after writeback. The regfile has no write-through.
REQ-025 SHALL drive busy_vec[n] = (cnt[n] != 0) and busy_vec[0] = 0, both registered-state derived.
REQ-026 SHALL increment stall_cycles by 1 on every edge where id_valid & ~id_ready_go.
REQ-027 SHALL saturate stall_cycles at 0xFFFFFFFF.
REQ-028 SHALL not count cycles where ID is blocked only by ex_allow_in = 0.
REQ-029 SHALL have zero latency from request to id_ready_go. Counter updates are visible one cycle after the causing edge.

Reset
REQ-030 SHALL, while reset = 1, hold all cnt = 0, busy_vec = 0, stall_cycles = 0, and id_ready_go = 1 (no pending writes).
REQ-031 SHALL, on reset asserted mid-operation, discard all pending-write tracking; the pipeline is reset concurrently.
REQ-032 SHALL make the first edge after reset deassertion perform normal updates.

Verification
REQ-033 SHALL pass: issue add r5 (gr_we=1, dest=5) with ex_allow_in=1 -> next cycle busy_vec = 0x20. A following instr with raddr1=5, use1=1 -> id_ready_go=0 and stall_cycles increments each cycle.
REQ-034 SHALL pass: after REQ-033, wb_we=1, wb_dest=5 -> id_ready_go stays 0 that cycle, then 1 the next cycle; busy_vec = 0.
REQ-035 SHALL pass: three issues writing r7 with no WB -> cnt[7]=3. A fourth writing r7 -> id_ready_go=0 (waw). One WB r7 -> next cycle id_ready_go=1.
REQ-036 SHALL pass: same cycle issue writing r9 and wb_dest=9 with cnt[9]=1 -> cnt[9] stays 1 and busy_vec[9]=1.
REQ-037 SHALL pass: issues writing r0 and reads of r0 -> busy_vec = 0 and id_ready_go = 1 throughout.
REQ-038 SHALL pass: reset asserted asynchronously between edges with busy_vec = 0x00000FF0 and stall_cycles = 12 -> immediately busy_vec = 0, stall_cycles = 0, id_ready_go = 1.
